decode_cycle: RTL
=================

Name: decode_cycle

Overview:
Decode stage of the 5-stage pipeline, the consumer of the fetch stage's IF/ID outputs (InstrD, PCD, PCPlus4D).
- Cracks the 33-bit instruction, reads the 16x32 register file, sign-extends the immediate and generates control.
- Registers everything into the ID/EX pipeline register.
- The fetch register has no flush, so this block squashes wrong-path instructions after a taken branch (PCSrcE), counting the cycles itself.
- Owns the register file write port driven from writeback.

Parameters:
FLUSH_CYCLES, 2, number of consecutive ID/EX bubbles inserted after PCSrcE is sampled high (1..3)
DATA_W, 32, register/data width
PC_W, 9, program-counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
InstrD  input  33  instruction from IF/ID
PCD  input  PC_W  PC of InstrD
PCPlus4D  input  PC_W  PCD+1 from fetch
PCSrcE  input  1  taken branch/jump resolved in execute this cycle
FlushE  input  1  hazard-unit request: load bubble into ID/EX this edge
RegWriteW  input  1  writeback enable
RdW  input  4  writeback destination
ResultW  input  DATA_W  writeback data
RD1E, RD2E  output  DATA_W  source operands
ImmExtE  output  DATA_W  sign-extended imm16
RdE, Rs1E, Rs2E  output  4  register indices (for forwarding)
PCE, PCPlus4E  output  PC_W  registered PCD, PCPlus4D
RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE  output  1  control
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or
IllegalE  output  1  undefined opcode reached execute

Behaviour:
- Reset is asynchronous, active-low, on rst. While rst=0:
  - all 16 registers = 0;
  - all ID/EX outputs = 0;
  - squash counter = 0.
- Encoding: [32:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16. ImmExt = imm16 sign-extended to DATA_W.
- Opcodes and control produced:
  - 0x00 NOP: all control 0.
  - 0x01 ADD / 0x02 SUB / 0x03 AND / 0x04 OR: RegWrite=1, ALUSrc=0, ALUControl 000/001/010/011.
  - 0x05 ADDI: RegWrite=1, ALUSrc=1, add.
  - 0x06 LOAD: RegWrite=1, ALUSrc=1, ResultSrc=1, add.
  - 0x07 STORE: MemWrite=1, ALUSrc=1, add.
  - 0x08 BEQ: Branch=1, sub.
  - 0x09 JMP: Jump=1.
  - Any other opcode: all control 0, IllegalE=1.
- Register file:
  - Asynchronous read, synchronous write on posedge when RegWriteW=1 and RdW!=0.
  - r0 reads 0 always.
  - Write-through bypass: if RegWriteW && RdW==rsX && rsX!=0, the read returns ResultW in the same cycle.
- Latency: one cycle. Decode of InstrD at cycle n appears on the E outputs after edge n.
- Squash counter (2 bits):
  - When PCSrcE=1 at an edge: ID/EX loads a bubble and the counter loads FLUSH_CYCLES-1.
  - At each later edge with counter>0: bubble, counter decrements.
  - PCSrcE=1 while counter>0: counter reloads to FLUSH_CYCLES-1 (no accumulation).
- Bubble definition:
  - RegWriteE, MemWriteE, BranchE, JumpE, IllegalE, ResultSrcE, ALUSrcE = 0, ALUControlE = 000.
  - Data, index and PC fields = 0.
- FlushE=1: bubble that edge only, counter unaffected. FlushE together with PCSrcE: PCSrcE rule applies.
- Register writeback is never squashed; it continues during bubbles.
- Reset mid-squash: counter cleared; the first edge after release loads a normal decode.

Decomposition:
- Package decode_pkg holds:
  - opcode enum (5 bits) and field bit positions;
  - ALUControl encodings;
  - a packed struct for the ID/EX control bundle plus a BUBBLE constant.
- Sub-module register_file (16xDATA_W, two read ports, one write port, bypass, r0 hard-zero), instantiated once.
- Decoder logic and the ID/EX register stay in decode_cycle.

Test Plan:
- Reset release then InstrD=ADD r3,r1,r2 (0x01,3,1,2) with r1=5, r2=7 preloaded via writeback -> next edge: RD1E=5, RD2E=7, RdE=3, RegWriteE=1, ALUControlE=000.
- ADDI imm16=0xFFFE -> ImmExtE=0xFFFFFFFE, ALUSrcE=1. LOAD -> ResultSrcE=1. STORE -> MemWriteE=1, RegWriteE=0.
- Writeback RdW=4, ResultW=0xDEAD in the same cycle InstrD reads rs1=4 -> RD1E=0xDEAD. Writeback to r0 with 0x1234 -> a later read of r0 gives 0.
- PCSrcE pulsed 1 cycle with FLUSH_CYCLES=2 and valid ADDs streaming -> exactly 2 consecutive bubbles (RegWriteE=0, PCE=0), then a normal decode. PCSrcE re-pulsed during the second bubble -> 2 further bubbles.
- Opcode 0x1F -> IllegalE=1 with all other control 0. FlushE pulse -> a single bubble.
- rst driven low mid-squash and while registers are nonzero -> outputs and registers 0 immediately (asynchronous). After release, the next instruction decodes normally with no bubble.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field layout, opcodes, ALU encodings
// and the ID/EX control bundle.
package decode_pkg;

  localparam int OPC_MSB = 32;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_ADD   = 5'h01,
    OP_SUB   = 5'h02,
    OP_AND   = 5'h03,
    OP_OR    = 5'h04,
    OP_ADDI  = 5'h05,
    OP_LOAD  = 5'h06,
    OP_STORE = 5'h07,
    OP_BEQ   = 5'h08,
    OP_JMP   = 5'h09
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_ctl_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     result_src;
    logic     branch;
    logic     jump;
    logic     alu_src;
    alu_ctl_e alu_ctl;
    logic     illegal;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/decode_cycle_register_file.sv
// 16-entry register file: two async read ports with write-through bypass,
// one sync write port, r0 hard-wired to zero.
module register_file #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr1,
  input  logic [3:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [15:0][DATA_W-1:0] mem_q, mem_d;
  logic [1:0][3:0]         raddr;
  logic [1:0][DATA_W-1:0]  rdata;

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != 4'd0) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign raddr = {raddr2, raddr1};

  // Bypass lets an instruction see the value being written back this cycle.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = '0;
      if (raddr[p] != 4'd0) begin
        if (we && waddr == raddr[p]) rdata[p] = wdata;
        else                         rdata[p] = mem_q[raddr[p]];
      end
    end
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: cracks IF/ID instruction, reads regfile, builds control and
// registers it into ID/EX, squashing wrong-path slots after a taken branch.
module decode_cycle
  import decode_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DATA_W       = 32,
  parameter int PC_W         = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32:0]       InstrD,
  input  logic [PC_W-1:0]   PCD,
  input  logic [PC_W-1:0]   PCPlus4D,
  input  logic              PCSrcE,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [3:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [3:0]        RdE,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E,
  output logic [PC_W-1:0]   PCE,
  output logic [PC_W-1:0]   PCPlus4E,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic              IllegalE
);

  localparam logic [1:0] SQ_RELOAD = 2'(FLUSH_CYCLES - 1);

  opcode_e           opcode;
  logic [3:0]        rd, rs1, rs2;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rd1, rd2, imm_ext;
  ctrl_t             ctrl_dec;
  logic              bubble;

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [3:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc4_q, pc4_d;
  logic [1:0]        sq_cnt_q, sq_cnt_d;

  assign opcode  = opcode_e'(InstrD[OPC_MSB:OPC_LSB]);
  assign rd      = InstrD[RD_MSB:RD_LSB];
  assign rs1     = InstrD[RS1_MSB:RS1_LSB];
  assign rs2     = InstrD[RS2_MSB:RS2_LSB];
  assign imm16   = InstrD[IMM_MSB:IMM_LSB];
  assign imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};

  register_file #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_comb begin
    ctrl_dec = BUBBLE;
    case (opcode)
      OP_NOP:   ;
      OP_ADD:   begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_ctl = ALU_ADD; end
      OP_SUB:   begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_ctl = ALU_SUB; end
      OP_AND:   begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_ctl = ALU_AND; end
      OP_OR:    begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_ctl = ALU_OR;  end
      OP_ADDI:  begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; end
      OP_LOAD:  begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.result_src = 1'b1;
      end
      OP_STORE: begin ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src = 1'b1; end
      OP_BEQ:   begin ctrl_dec.branch = 1'b1; ctrl_dec.alu_ctl = ALU_SUB; end
      OP_JMP:   ctrl_dec.jump = 1'b1;
      default:  ctrl_dec.illegal = 1'b1;
    endcase
  end

  // A new taken branch always restarts the squash window rather than extending it.
  assign bubble = PCSrcE || (sq_cnt_q != 2'd0) || FlushE;

  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (PCSrcE)                 sq_cnt_d = SQ_RELOAD;
    else if (sq_cnt_q != 2'd0)  sq_cnt_d = sq_cnt_q - 2'd1;

    ctrl_d = BUBBLE;
    rd1_d  = '0;
    rd2_d  = '0;
    imm_d  = '0;
    rd_d   = '0;
    rs1_d  = '0;
    rs2_d  = '0;
    pc_d   = '0;
    pc4_d  = '0;
    if (!bubble) begin
      ctrl_d = ctrl_dec;
      rd1_d  = rd1;
      rd2_d  = rd2;
      imm_d  = imm_ext;
      rd_d   = rd;
      rs1_d  = rs1;
      rs2_d  = rs2;
      pc_d   = PCD;
      pc4_d  = PCPlus4D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= BUBBLE;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      pc4_q    <= '0;
      sq_cnt_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign RdE         = rd_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUControlE = ctrl_q.alu_ctl;
  assign IllegalE    = ctrl_q.illegal;

endmodule
